// File: rtl/irq_ctrl.sv
// Interrupt, syscall and fault controller beside the microcode decoder.
// Synchronises device lines, prioritises traps and keeps a one-level save slot.
module irq_ctrl #(
  parameter int          NIRQ  = 4,
  parameter logic [3:0]  EXECM = 4'b1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            fault_in,
  input  logic [3:0]      state,
  input  logic            syscall,
  input  logic            reti,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wdata,
  input  logic            ie_we,
  input  logic            ie_wdata,
  output logic            irq_r,
  output logic            fault_r,
  output logic [3:0]      cause,
  output logic            ie,
  output logic            mode,
  output logic [NIRQ-1:0] pending,
  output logic [NIRQ-1:0] mask,
  output logic            dfault
);

  logic [NIRQ-1:0] s1_q, s2_q, s3_q, pending_q, pending_d, mask_q, mask_d;
  logic [NIRQ-1:0] rise, masked, clr;
  logic            irq_r_q, irq_r_d, fault_r_q, fault_r_d;
  logic [3:0]      cause_q, cause_d, irq_idx;
  logic            ie_q, ie_d, mode_q, mode_d, dfault_q, dfault_d;
  logic            prev_ie_q, prev_ie_d, prev_mode_q, prev_mode_d, in_trap_q, in_trap_d;
  logic            in_exec, take_flt, take_sc, take_irq, entry, ret, save;

  assign rise   = s2_q & ~s3_q;
  assign masked = pending_q & mask_q;

  always_comb begin
    irq_idx = '0;
    clr     = '0;
    // Ascending scan: the last hit is the highest-numbered line.
    for (int i = 0; i < NIRQ; i++)
      if (masked[i]) irq_idx = 4'(i);

    in_exec  = (state == EXECM);
    take_flt = fault_in;
    take_sc  = !fault_in && in_exec && syscall;
    take_irq = !fault_in && !take_sc && in_exec && irq_r_q;
    entry    = take_flt || take_sc || take_irq;
    ret      = in_exec && reti && !entry;
    // A nested fault must not clobber the context of the trap it interrupts.
    save     = entry && !(take_flt && in_trap_q);

    for (int i = 0; i < NIRQ; i++)
      if (take_irq && masked[i] && irq_idx == 4'(i)) clr[i] = 1'b1;

    pending_d   = (pending_q & ~clr) | rise;
    mask_d      = mask_we ? mask_wdata : mask_q;
    irq_r_d     = ie_q && |masked;
    fault_r_d   = take_flt;
    dfault_d    = dfault_q || (take_flt && in_trap_q);
    prev_ie_d   = save ? ie_q   : prev_ie_q;
    prev_mode_d = save ? mode_q : prev_mode_q;

    cause_d   = cause_q;
    ie_d      = ie_we ? ie_wdata : ie_q;
    mode_d    = mode_q;
    in_trap_d = in_trap_q;
    if (entry) begin
      cause_d   = take_flt ? 4'd9 : (take_sc ? 4'd8 : irq_idx);
      ie_d      = 1'b0;
      mode_d    = 1'b1;
      in_trap_d = 1'b1;
    end else if (ret) begin
      ie_d      = prev_ie_q;
      mode_d    = prev_mode_q;
      in_trap_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      irq_r_q     <= 1'b0;
      fault_r_q   <= 1'b0;
      cause_q     <= '0;
      ie_q        <= 1'b0;
      mode_q      <= 1'b1;
      dfault_q    <= 1'b0;
      prev_ie_q   <= 1'b0;
      prev_mode_q <= 1'b0;
      in_trap_q   <= 1'b0;
    end else begin
      s1_q        <= irq_in;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      irq_r_q     <= irq_r_d;
      fault_r_q   <= fault_r_d;
      cause_q     <= cause_d;
      ie_q        <= ie_d;
      mode_q      <= mode_d;
      dfault_q    <= dfault_d;
      prev_ie_q   <= prev_ie_d;
      prev_mode_q <= prev_mode_d;
      in_trap_q   <= in_trap_d;
    end
  end

  assign irq_r   = irq_r_q;
  assign fault_r = fault_r_q;
  assign cause   = cause_q;
  assign ie      = ie_q;
  assign mode    = mode_q;
  assign pending = pending_q;
  assign mask    = mask_q;
  assign dfault  = dfault_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: per-edge vector table plus a hand-written
// sequence for a new edge arriving on the same edge its line is serviced.
module tb_irq_ctrl;
  localparam logic [3:0] X = 4'b1000;

  logic       clk = 1'b0;
  logic       reset, fault_in, syscall, reti, mask_we, ie_we, ie_wdata;
  logic [3:0] irq_in, state, mask_wdata;
  logic       irq_r, fault_r, ie, mode, dfault;
  logic [3:0] cause, pending, mask;

  int tests = 0, fails = 0;

  irq_ctrl #(.NIRQ(4), .EXECM(4'b1000)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .fault_in(fault_in), .state(state),
    .syscall(syscall), .reti(reti), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .ie_we(ie_we), .ie_wdata(ie_wdata), .irq_r(irq_r), .fault_r(fault_r),
    .cause(cause), .ie(ie), .mode(mode), .pending(pending), .mask(mask), .dfault(dfault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;  logic [3:0] irq; logic flt; logic [3:0] st;
    logic       sc;   logic rt; logic mwe; logic [3:0] md; logic iwe; logic id;
    logic [16:0] exp; // {irq_r,fault_r,cause,ie,mode,pending,mask,dfault}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] irq, input logic flt, input logic [3:0] st,
                     input logic sc, input logic rt, input logic mwe, input logic [3:0] md,
                     input logic iwe, input logic id,
                     input logic xr, input logic xf, input logic [3:0] xc, input logic xie,
                     input logic xm, input logic [3:0] xp, input logic [3:0] xmk, input logic xd);
    vec_t v;
    v.rst = rst; v.irq = irq; v.flt = flt; v.st = st; v.sc = sc; v.rt = rt;
    v.mwe = mwe; v.md = md; v.iwe = iwe; v.id = id;
    v.exp = {xr, xf, xc, xie, xm, xp, xmk, xd};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic [3:0] irq, input logic flt, input logic [3:0] st,
                       input logic sc, input logic rt, input logic mwe, input logic [3:0] md,
                       input logic iwe, input logic id);
    @(negedge clk);
    reset = rst; irq_in = irq; fault_in = flt; state = st; syscall = sc; reti = rt;
    mask_we = mwe; mask_wdata = md; ie_we = iwe; ie_wdata = id;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {irq_r, fault_r, cause, ie, mode, pending, mask, dfault};
  endfunction

  initial begin
    reset = 1; irq_in = 0; fault_in = 0; state = 0; syscall = 0; reti = 0;
    mask_we = 0; mask_wdata = 0; ie_we = 0; ie_wdata = 0;

    //   rst irq  flt st sc rt mwe md iwe id | irq_r f_r cause ie mode pend mask df
    // reset with all lines high; edges seen 3 edges after release
    add(1, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 4'h0, 4'h0, 0); // 0
    add(1, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 4'h0, 4'h0, 0);
    add(0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 4'h0, 4'h0, 0);
    add(0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 4'h0, 4'h0, 0);
    add(0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 4'hF, 4'h0, 0);
    add(1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 4'h0, 4'h0, 0); // 5
    // mask 0110, ie 1, pulse lines 1 and 2
    add(0, 4'h0, 0, 0, 0, 0, 1, 6, 1, 1,   0, 0, 0, 1, 1, 4'h0, 4'h6, 0);
    add(0, 4'h6, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 4'h0, 4'h6, 0);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 4'h0, 4'h6, 0);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 4'h6, 4'h6, 0);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 4'h6, 4'h6, 0); // 10
    add(0, 4'h0, 0, X, 0, 0, 0, 0, 0, 0,   1, 0, 2, 0, 1, 4'h2, 4'h6, 0);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0, 1, 4'h2, 4'h6, 0);
    add(0, 4'h0, 0, X, 0, 1, 0, 0, 0, 0,   0, 0, 2, 1, 1, 4'h2, 4'h6, 0);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 2, 1, 1, 4'h2, 4'h6, 0);
    add(0, 4'h0, 0, X, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 1, 4'h0, 4'h6, 0); // 15
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1, 4'h0, 4'h6, 0);
    add(0, 4'h0, 0, X, 0, 1, 0, 0, 0, 0,   0, 0, 1, 1, 1, 4'h0, 4'h6, 0);
    // syscall beats a pending irq; irq retaken later with cause 0
    add(0, 4'h1, 0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 1, 1, 1, 4'h0, 4'h1, 0);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1, 4'h0, 4'h1, 0);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1, 4'h1, 4'h1, 0); // 20
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 1, 4'h1, 4'h1, 0);
    add(0, 4'h0, 0, X, 1, 0, 0, 0, 0, 0,   1, 0, 8, 0, 1, 4'h1, 4'h1, 0);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 8, 0, 1, 4'h1, 4'h1, 0);
    add(0, 4'h0, 0, X, 0, 1, 0, 0, 0, 0,   0, 0, 8, 1, 1, 4'h1, 4'h1, 0);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 8, 1, 1, 4'h1, 4'h1, 0); // 25
    add(0, 4'h0, 0, X, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 4'h0, 4'h1, 0);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 4'h0, 4'h1, 0);
    add(0, 4'h0, 0, X, 0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 1, 4'h0, 4'h1, 0);
    // reset, then reti outside a trap restores the zeroed save slots (user mode)
    add(1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 4'h0, 4'h0, 0);
    add(0, 4'h0, 0, X, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 4'h0, 4'h0, 0); // 30
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 0, 4'h0, 4'h0, 0);
    // fault from user mode, then return
    add(0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 9, 0, 1, 4'h0, 4'h0, 0);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 9, 0, 1, 4'h0, 4'h0, 0);
    add(0, 4'h0, 0, X, 0, 1, 0, 0, 0, 0,   0, 0, 9, 1, 0, 4'h0, 4'h0, 0);
    // double fault: save slots keep ie=1/mode=0 from the first fault
    add(0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 9, 0, 1, 4'h0, 4'h0, 0); // 35
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 9, 0, 1, 4'h0, 4'h0, 0);
    add(0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 9, 0, 1, 4'h0, 4'h0, 1);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 9, 0, 1, 4'h0, 4'h0, 1);
    add(0, 4'h0, 0, X, 0, 1, 0, 0, 0, 0,   0, 0, 9, 1, 0, 4'h0, 4'h0, 1);
    // ie write loses to an irq entry on the same edge
    add(0, 4'h8, 0, 0, 0, 0, 1, 8, 0, 0,   0, 0, 9, 1, 0, 4'h0, 4'h8, 1); // 40
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 9, 1, 0, 4'h0, 4'h8, 1);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 9, 1, 0, 4'h8, 4'h8, 1);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 9, 1, 0, 4'h8, 4'h8, 1);
    add(0, 4'h0, 0, X, 0, 0, 0, 0, 1, 1,   1, 0, 3, 0, 1, 4'h0, 4'h8, 1);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 3, 0, 1, 4'h0, 4'h8, 1); // 45
    add(0, 4'h0, 0, X, 0, 1, 0, 0, 0, 0,   0, 0, 3, 1, 0, 4'h0, 4'h8, 1);
    // fault coinciding with an irq entry: irq stays pending
    add(0, 4'h8, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 3, 1, 0, 4'h0, 4'h8, 1);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 3, 1, 0, 4'h0, 4'h8, 1);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 3, 1, 0, 4'h8, 4'h8, 1);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 3, 1, 0, 4'h8, 4'h8, 1); // 50
    add(0, 4'h0, 1, X, 0, 0, 0, 0, 0, 0,   1, 1, 9, 0, 1, 4'h8, 4'h8, 1);
    add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 9, 0, 1, 4'h8, 4'h8, 1);
    // reset mid-trap drops everything, including the pending edge and dfault
    add(1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 4'h0, 4'h0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].irq, vecs[i].flt, vecs[i].st, vecs[i].sc, vecs[i].rt,
            vecs[i].mwe, vecs[i].md, vecs[i].iwe, vecs[i].id);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // New edge on line 1 lands on the very edge line 1 is serviced: set wins.
    drive(1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 4'h2, 0, 0, 0, 0, 1, 2, 1, 1);        // E0
    drive(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);        // E1
    drive(0, 4'h2, 0, 0, 0, 0, 0, 0, 0, 0);        // E2: first edge latched
    check("seq_pend_first", {13'd0, pending}, {13'd0, 4'h2});
    drive(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);        // E3: request raised
    check("seq_irq_r", {16'd0, irq_r}, 17'd1);
    drive(0, 4'h0, 0, X, 0, 0, 0, 0, 0, 0);        // E4: entry + second rise
    check("seq_cause", {13'd0, cause}, 17'd1);
    check("seq_pend_kept", {13'd0, pending}, {13'd0, 4'h2});
    check("seq_ie_mode", {15'd0, ie, mode}, 17'b01);
    drive(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("seq_pend_after", {13'd0, pending}, {13'd0, 4'h2});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt, syscall and fault controller that sits beside the microcode decoder. It produces the decoder's `irq_r` and `fault_r` inputs, and consumes the decoder's `state`, `SYSCALL` and `RETI` outputs. It synchronises and edge-detects device interrupt lines, masks and prioritises them, and performs trap entry and return bookkeeping: cause code, global interrupt enable and supervisor mode, each with a one-level save slot.

## Interface
- `NIRQ`, 4: number of device interrupt lines (cause codes 0..NIRQ-1; max 8).
- `EXECM`, 4'b1000: decoder state encoding at which traps are taken.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high.
- `irq_in`  in  NIRQ  asynchronous level interrupt lines; a rising edge requests service.
- `fault_in`  in  1  synchronous fault pulse from the MMU/bus.
- `state`  in  4  decoder state.
- `syscall`  in  1  decoder `SYSCALL`.
- `reti`  in  1  decoder `RETI`.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_wdata`  in  NIRQ  new mask value.
- `ie_we`  in  1  write strobe for the global enable.
- `ie_wdata`  in  1  new global enable value.
- `irq_r`  out  1  registered interrupt request to the decoder.
- `fault_r`  out  1  one-cycle registered fault pulse to the decoder.
- `cause`  out  4  cause of the last trap entry.
- `ie`  out  1  global interrupt enable.
- `mode`  out  1  1 = supervisor, 0 = user.
- `pending`  out  NIRQ  latched, unserviced interrupt edges.
- `mask`  out  NIRQ  per-line enable.
- `dfault`  out  1  sticky double-fault flag.

## Operation
- Reset values:
  - `irq_r`, `fault_r`, `cause`, `ie`, `pending`, `mask`, `dfault`, and the save slots `prev_ie`, `prev_mode`, `in_trap`: all 0.
  - `mode`: 1.
  - Synchronisers: 0.
- Synchronisation: each `irq_in` bit passes through a two-flop synchroniser `s1`→`s2`, with a third flop `s3` for edge detection. `rise = s2 & ~s3`.
- Pending:
  - `pending[i]` sets on `rise[i]`.
  - It clears only when line i is the line taken at entry.
  - Set and clear on the same edge: set wins, so the new edge is kept.
- Request: `irq_r <= ie & |(pending & mask)`, registered every cycle.
- Trap entry, evaluated at each rising edge. Priority is fault > syscall > irq.
  - Fault: `fault_in` = 1, in any state. Effects: `fault_r <= 1` for exactly one cycle; `cause <= 9`.
  - Syscall: `state == EXECM` and `syscall`. Effect: `cause <= 8`.
  - Irq: `state == EXECM` and `irq_r`. Effects: `cause <=` highest set index of `pending & mask`; that pending bit clears.
  - Every entry also does: `prev_ie <= ie`, `prev_mode <= mode`, `ie <= 0`, `mode <= 1`, `in_trap <= 1`.
  - A lower-priority source losing arbitration keeps its pending bit and is retaken later.
- Return: `state == EXECM`, `reti`, and no entry on the same edge. Effects: `ie <= prev_ie`, `mode <= prev_mode`, `in_trap <= 0`.
  - `reti` with `in_trap == 0` still restores from the save slots.
- Double fault: a fault while `in_trap == 1` sets `dfault` (sticky until reset). The entry still occurs, but the save slots are NOT overwritten.
- Software writes:
  - `mask_we` writes `mask` unconditionally.
  - `ie_we` writes `ie` unless a trap entry or return occurs on the same edge; in that case entry/return wins.
- `syscall` and `reti` are never both set by microcode. If they are, `syscall` is treated as taking priority and `reti` is ignored.

## Timing
- `irq_in` rising before edge E0:
  - `s1` = 1 after E0, `s2` after E1.
  - `pending` set after E2.
  - `irq_r` high after E3, provided `ie` and the mask bit are set.
- Entry is taken at the rising edge inside EXECM. The decoder samples `irq_r`/`fault_r` on the following negedge and branches to state 0.
- `irq_r` falls the cycle after entry, because `ie` cleared.
- `fault_r` is high for exactly the one cycle following the edge where `fault_in` was sampled.
- `cause`, `ie`, `mode` and `pending` update on the entry edge and are valid from the next cycle.
- A fault mid-EXECM that coincides with an irq entry: the fault is taken, and the irq remains pending.
- Reset asserted mid-trap: all state returns to reset values on the next edge. Pending edges are lost.

## Test plan
- Reset → `mode`=1, all other outputs 0. With `irq_in`=4'b1111 held during reset and reset then released, `pending` is set 3 edges after release, because the edges are detected only once the synchronisers fill.
- `mask`=4'b0110, `ie`=1, pulse `irq_in`[1] and [2] together → `irq_r` rises 4 edges later. First EXECM gives `cause`=2 and `pending`=4'b0010. After `reti`, `ie`=1 again, and the next EXECM gives `cause`=1.
- `ie`=1, `pending`[0] set and masked in, with `syscall` at EXECM → `cause`=8, `pending`[0] still 1, `ie`=0, `mode`=1.
- `mode`=0, `ie`=1, `fault_in` pulse → `fault_r` high 1 cycle, `cause`=9. `reti` then restores `mode`=0, `ie`=1.
- Fault during a handler (`in_trap`=1) → `dfault`=1, with `prev_ie`/`prev_mode` unchanged. Verify via the values restored by `reti`.
- `ie_we` with `ie_wdata`=1 on the same edge as an irq entry → `ie`=0 afterwards.
